// File: rtl/regfile_dump_reader_if.sv
// Byte-stream valid/ready channel carrying the serialised register dump.
interface regfile_dump_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks registers FIRST_REG..LAST_REG through a read port, snapshots each word and
// streams it as {index, data[31:24], [23:16], [15:8], [7:0]} over a valid/ready byte channel.
module regfile_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  output logic [4:0]                   rf_addr,
  input  logic [31:0]                  rf_data,
  regfile_dump_reader_if.master        tx,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND_IDX,
    S_SEND_DATA,
    S_DONE
  } state_e;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] shreg_q, shreg_d;

  logic       tx_valid_w;
  logic [7:0] tx_data_w;
  logic       xfer;

  assign tx.tx_valid = tx_valid_w;
  assign tx.tx_data  = tx_data_w;
  assign xfer        = tx_valid_w && tx.tx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= FIRST_IDX;
      bcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Outputs decode from state only, so tx_valid never sees tx_ready combinationally.
  always_comb begin
    tx_valid_w = 1'b0;
    tx_data_w  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    rf_addr    = idx_q;
    case (state_q)
      S_IDLE:      rf_addr = FIRST_IDX;
      S_LOAD:      busy = 1'b1;
      S_SEND_IDX: begin
        busy       = 1'b1;
        tx_valid_w = 1'b1;
        tx_data_w  = {3'b000, idx_q};
      end
      S_SEND_DATA: begin
        busy       = 1'b1;
        tx_valid_w = 1'b1;
        tx_data_w  = shreg_q[31:24];
      end
      S_DONE:      done = 1'b1;
      default:     ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d = rf_data;
        state_d = S_SEND_IDX;
      end
      S_SEND_IDX: begin
        if (xfer) begin
          bcnt_d  = '0;
          state_d = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        if (xfer) begin
          shreg_d = {shreg_q[23:0], 8'h00};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort cancels any busy state and also masks a simultaneous start in IDLE.
    if (abort && (state_q != S_DONE)) begin
      state_d = S_IDLE;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps, backpressure, sub-range,
// snapshot, ignored start, abort and asynchronous reset.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] rf [32];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // DUT A: default range 0..31
  logic        start_a, abort_a, busy_a, done_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a;
  regfile_dump_reader_if txa();
  assign data_a = (addr_a == 5'd0) ? 32'h0 : rf[addr_a];

  regfile_dump_reader dut_a (
    .clk     (clk),
    .reset   (reset),
    .start   (start_a),
    .abort   (abort_a),
    .rf_addr (addr_a),
    .rf_data (data_a),
    .tx      (txa),
    .busy    (busy_a),
    .done    (done_a)
  );

  // DUT B: range 2..3
  logic        start_b, abort_b, busy_b, done_b;
  logic [4:0]  addr_b;
  logic [31:0] data_b;
  regfile_dump_reader_if txb();
  assign data_b = (addr_b == 5'd0) ? 32'h0 : rf[addr_b];
  assign txb.tx_ready = 1'b1;

  regfile_dump_reader #(.FIRST_REG(2), .LAST_REG(3)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .start   (start_b),
    .abort   (abort_b),
    .rf_addr (addr_b),
    .rf_data (data_b),
    .tx      (txb),
    .busy    (busy_b),
    .done    (done_b)
  );

  logic bp_en = 1'b0;
  always @(negedge clk) txa.tx_ready <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         stab_err = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] held = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      if (txa.tx_valid && txa.tx_ready) qa.push_back(txa.tx_data);
      if (hold_pend && (!txa.tx_valid || txa.tx_data !== held)) stab_err <= stab_err + 1;
      hold_pend <= txa.tx_valid && !txa.tx_ready;
      held      <= txa.tx_data;
    end else begin
      hold_pend <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset && txb.tx_valid && txb.tx_ready) qb.push_back(txb.tx_data);
  end

  function automatic logic [7:0] exp_byte(input int k);
    int r;
    int p;
    logic [31:0] w;
    r = k / 5;
    p = k % 5;
    w = (r == 0) ? 32'h0 : 32'h1000_0000 + 32'(r);
    if (p == 0) return 8'(r);
    return 8'(w >> (8 * (4 - p)));
  endfunction

  int done_cyc, busy_n, base;

  // mode: 0 plain, 1 mid-dump start + x5 rewrite, 2 abort in reg 4 byte 3, 3 async reset
  task automatic run_a(input int mode);
    int cyc;
    base     = qa.size();
    done_cyc = 0;
    busy_n   = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (busy_a) busy_n++;
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
      if (mode == 2 && cyc == 30) begin
        abort_a = 1'b0;
        break;
      end
      start_a = (mode == 1 && cyc == 20);
      if (mode == 1 && cyc == 33) rf[5] = 32'h55;
      if (mode == 2 && cyc == 29) abort_a = 1'b1;
      if (mode == 3 && cyc == 50) begin
        @(posedge clk);
        #2 reset = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic verify_full(input string tag);
    check({tag, " len"}, 32'(qa.size() - base), 32'd160);
    for (int k = 0; k < 160; k++) begin
      if (base + k < qa.size())
        check($sformatf("%s byte %0d", tag, k), 32'(qa[base + k]), 32'(exp_byte(k)));
    end
  endtask

  logic [7:0] exp_b [10];
  int cyc_b, done_cyc_b, base_b, seen_done;

  initial begin
    reset   = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    exp_b = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h03, 8'h80, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("rst busy",    32'(busy_a),       32'd0);
    check("rst done",    32'(done_a),       32'd0);
    check("rst valid",   32'(txa.tx_valid), 32'd0);
    check("rst data",    32'(txa.tx_data),  32'd0);
    check("rst addr a",  32'(addr_a),       32'd0);
    check("rst addr b",  32'(addr_b),       32'd2);
    reset = 1'b1;

    run_a(0);
    check("plain done cyc", 32'(done_cyc), 32'd193);
    check("plain busy cyc", 32'(busy_n),   32'd192);
    @(negedge clk);
    check("plain done pulse", 32'(done_a), 32'd0);
    verify_full("plain");

    bp_en = 1'b1;
    run_a(0);
    bp_en = 1'b0;
    check("bp done seen", 32'(done_cyc > 0),   32'd1);
    check("bp stalled",   32'(done_cyc > 193), 32'd1);
    check("bp stable",    32'(stab_err),       32'd0);
    verify_full("bp");

    rf[2] = 32'hDEAD_BEEF;
    rf[3] = 32'h8000_0000;
    base_b = qb.size();
    done_cyc_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc_b = 1;
    while (cyc_b < 100) begin
      if (done_b) begin
        done_cyc_b = cyc_b;
        break;
      end
      @(negedge clk);
      cyc_b++;
    end
    check("sub done cyc", 32'(done_cyc_b), 32'd13);
    check("sub len", 32'(qb.size() - base_b), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (base_b + k < qb.size())
        check($sformatf("sub byte %0d", k), 32'(qb[base_b + k]), 32'(exp_b[k]));
    end
    rf[2] = 32'h1000_0002;
    rf[3] = 32'h1000_0003;

    run_a(1);
    rf[5] = 32'h1000_0005;
    check("snap done cyc", 32'(done_cyc), 32'd193);
    verify_full("snap");
    repeat (5) @(negedge clk);
    check("start not queued", 32'(busy_a), 32'd0);

    run_a(2);
    check("abort valid", 32'(txa.tx_valid), 32'd0);
    check("abort busy",  32'(busy_a),       32'd0);
    seen_done = 0;
    repeat (10) begin
      if (done_a) seen_done++;
      @(negedge clk);
    end
    check("abort no done", 32'(seen_done), 32'd0);
    check("abort len", 32'(qa.size() - base), 32'd24);
    if (qa.size() >= base + 24) begin
      check("abort idx byte", 32'(qa[base + 20]), 32'h04);
      check("abort last",     32'(qa[base + 23]), 32'(exp_byte(23)));
    end

    run_a(3);
    #1;
    check("areset valid", 32'(txa.tx_valid), 32'd0);
    check("areset busy",  32'(busy_a),       32'd0);
    check("areset done",  32'(done_a),       32'd0);
    check("areset data",  32'(txa.tx_data),  32'd0);
    check("areset addr",  32'(addr_a),       32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_a(0);
    check("post rst done cyc", 32'(done_cyc), 32'd193);
    verify_full("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the single-cycle core's register file. On a start pulse it walks a contiguous range of architectural registers through a dedicated register-file read port and snapshots each word. It streams each register out as a framed byte sequence over a valid/ready byte interface, where the UART transmitter or the seven-segment/LED debug path consumes it. It is the reader counterpart of the register-file write path: it never writes, it only observes and serialises.

## Interface
- `FIRST_REG`, default 0: first register index dumped (0..31).
- `LAST_REG`, default 31: last register index dumped (FIRST_REG..31).
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is released synchronously to `clk` by the top level.
- `start` in 1: request a dump. Sampled only in IDLE.
- `abort` in 1: synchronous cancel of a dump in progress.
- `rf_addr` out 5: register-file read address. The register file returns `rf_data` combinationally in the same cycle.
- `rf_data` in 32: register-file read data. Register 0 reads 0.
- `tx_data` out 8: byte being offered.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: consumer accepts the byte. A transfer occurs on a rising edge with `tx_valid && tx_ready`.
- `busy` out 1: high in LOAD, SEND_IDX and SEND_DATA.
- `done` out 1: one-cycle pulse after the final byte of a completed dump.

## Operation
- FSM states: IDLE, LOAD, SEND_IDX, SEND_DATA, DONE.
- **IDLE**
  - `rf_addr` is held at FIRST_REG.
  - With `start`=1: load the index counter to FIRST_REG and go to LOAD.
- **LOAD** (one cycle)
  - `rf_addr` = index counter.
  - Capture `rf_data` into a 32-bit shift register. This is the snapshot; later writes to that register are not reflected.
  - Go to SEND_IDX.
- **SEND_IDX**
  - `tx_valid`=1, `tx_data` = {3'b000, index}.
  - On transfer: go to SEND_DATA with the byte counter set to 0.
- **SEND_DATA**
  - `tx_valid`=1, `tx_data` = shift register [31:24], so bytes go out MSB first.
  - On transfer: shift left by 8 and increment the byte counter.
  - After the 4th transfer:
    - If index == LAST_REG, go to DONE.
    - Otherwise increment the index and go to LOAD.
- **DONE** (one cycle): `done`=1, `busy`=0, then go to IDLE.
- **Frame format:** 5 bytes per register (index, then data[31:24], [23:16], [15:8], [7:0]). Total length is 5 × (LAST_REG − FIRST_REG + 1) bytes.
- **Handshake rules**
  - Once `tx_valid` rises, `tx_valid` and `tx_data` stay stable until the transfer.
  - `tx_valid` never depends combinationally on `tx_ready`.
- **`start` while busy or in DONE:** ignored and not queued.
- **`abort`** in any busy state, or in the same cycle as a pending transfer:
  - The transfer that edge still counts for the consumer.
  - The FSM goes to IDLE next edge, `tx_valid` drops, and no `done` is pulsed.
  - `abort` in IDLE has no effect, and `abort` has priority over `start`.
- **Reset:** all outputs go low immediately (`tx_data`=0, `rf_addr`=FIRST_REG) and the FSM enters IDLE, including mid-frame. A partially sent frame is not resumed.
- **Width rules:** the index counter is 5 bits and never wraps, because LAST_REG ≤ 31 ends the dump before overflow. The byte counter is 2 bits.

## Timing
- `start` sampled at edge E0:
  - LOAD during cycle E0→E1.
  - `tx_valid`=1 with the index byte from E1.
- With `tx_ready` held high, each register takes 6 cycles (LOAD + 5 bytes).
- A full 0..31 dump has `busy` high for 192 cycles, followed by the `done` pulse in cycle 193.
- Throughput with stalls: one byte per cycle with `tx_ready`=1. There is no bubble between bytes of one register and exactly one LOAD bubble between registers.
- `done` to next accepted `start`: `start` may be sampled in the cycle after DONE (IDLE), giving a minimum one-cycle gap.

## Test plan
- **Default parameters, registers loaded with x[i] = 0x1000_0000 + i, `tx_ready`=1, pulse `start`:**
  - 160 bytes; first frame 00 00 00 00 00, since x0 reads 0.
  - Second frame 01 10 00 00 01; last frame 1F 10 00 00 1F.
  - `done` exactly 193 cycles after `start`.
- **Random `tx_ready` backpressure (50%):** byte stream identical to the previous test; `tx_data` is stable on every cycle with `tx_valid`=1 and `tx_ready`=0.
- **FIRST_REG=2, LAST_REG=3, x2=0xDEADBEEF, x3=0x80000000:** stream 02 DE AD BE EF 03 80 00 00 00, then `done`.
- **Snapshot:** write x5=0x55 during the x5 SEND_DATA phase; the frame still carries the value captured at LOAD.
- **`start` pulsed mid-dump:** ignored. **`abort` during the third data byte of reg 4:** `tx_valid` goes low next cycle, `busy`=0, no `done`.
- **`reset` driven low mid-frame, asynchronously between edges:** `tx_valid`, `busy` and `done` go to 0 without a clock edge. After release, a fresh `start` produces a full, correct dump from FIRST_REG.
